// File: rtl/data_mem_port.sv
// rtl/data_mem_port.sv - MEM-stage data-memory responder: CPU load/store strobes to a req/ack bus with pipeline stall.
module data_mem_port #(
    parameter int AW      = 14,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          bus_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata
);

    // A zero-width counter is illegal, so TIMEOUT=0 still keeps one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          start;
    logic          timeout_hit;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign start            = mem_rd | mem_wr;
    assign timeout_hit      = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The pipeline must not be frozen while the block is being reset.
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            bus_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_we    <= mem_wr;
                        bus_addr  <= addr[AW+1:2];
                        bus_wdata <= wdata;
                        bus_req   <= 1'b1;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        if (!bus_we) begin
                            rdata <= 32'hDEAD_BEEF;
                        end
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// tb/tb_data_mem_port.sv - directed table-driven bench for data_mem_port.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, bus_err, bus_req, bus_we;
    logic [13:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        t_reset, t_mem_rd, t_mem_wr, t_bus_ack;
    logic [31:0] t_addr, t_wdata, t_bus_rdata;
    logic [31:0] t_rdata, t_bus_wdata;
    logic        t_stall, t_bus_err, t_bus_req, t_bus_we;
    logic [13:0] t_bus_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_port dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    data_mem_port #(.AW(14), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(t_reset), .mem_rd(t_mem_rd), .mem_wr(t_mem_wr),
        .addr(t_addr), .wdata(t_wdata), .rdata(t_rdata), .stall(t_stall),
        .bus_err(t_bus_err), .bus_req(t_bus_req), .bus_we(t_bus_we),
        .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata), .bus_ack(t_bus_ack),
        .bus_rdata(t_bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_dly;
        logic [31:0] rin;
        logic        exp_we;
        logic [13:0] exp_addr;
        int          exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int          stall_n;
        logic        held_ok;
        logic        done;
        logic [5:0]  st_pat, req_pat;
        int          req_n;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,           1,  32'h1234_5678, 1'b0, 14'h0004, 2,  32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D,   5,  32'h5555_AAAA, 1'b1, 14'h0009, 6,  32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,           3,  32'hA5A5_0F0F, 1'b0, 14'h3FFF, 4,  32'hA5A5_0F0F};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1111_2222,   2,  32'h9999_9999, 1'b1, 14'h0002, 3,  32'hA5A5_0F0F};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_0007, 32'h0,           1,  32'h0000_0000, 1'b0, 14'h0001, 2,  32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,           64, 32'h0BAD_F00D, 1'b0, 14'h0010, 65, 32'h0BAD_F00D};

        reset = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h10; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        t_reset = 1'b1; t_mem_rd = 1'b0; t_mem_wr = 1'b0; t_addr = 32'h0; t_wdata = 32'h0;
        t_bus_ack = 1'b0; t_bus_rdata = 32'h0;
        tick();
        tick();
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_req", {31'b0, bus_req}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_busfields", {bus_we, bus_err, bus_addr, 16'h0} | bus_wdata, 32'h0);
        reset = 1'b0; t_reset = 1'b0; mem_rd = 1'b0;
        tick();

        // Ack while idle must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_req", {31'b0, bus_req}, 32'h0);
        check("idle_ack_rdata", rdata, 32'h0);
        check("idle_ack_stall", {31'b0, stall}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            stall_n = 0; held_ok = 1'b1; done = 1'b0;
            mem_rd = vecs[v].rd; mem_wr = vecs[v].wr; addr = vecs[v].a; wdata = vecs[v].wd;
            #1;
            if (stall) stall_n++;
            tick();
            for (int k = 1; k <= 100; k++) begin
                bus_ack = (k == vecs[v].ack_dly); bus_rdata = vecs[v].rin;
                #1;
                if (stall) stall_n++;
                if (bus_req !== 1'b1 || bus_we !== vecs[v].exp_we ||
                    bus_addr !== vecs[v].exp_addr || bus_wdata !== vecs[v].wd) held_ok = 1'b0;
                tick();
                bus_ack = 1'b0;
                if (bus_req === 1'b0) begin
                    done = 1'b1;
                    break;
                end
            end
            check($sformatf("v%0d_done", v), {31'b0, done}, 32'h1);
            check($sformatf("v%0d_held", v), {31'b0, held_ok}, 32'h1);
            check($sformatf("v%0d_stall_cycles", v), stall_n, vecs[v].exp_stall);
            check($sformatf("v%0d_done_stall", v), {31'b0, stall}, 32'h0);
            check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_err", v), {31'b0, bus_err}, 32'h0);
            mem_rd = 1'b0; mem_wr = 1'b0;
            tick();
            check($sformatf("v%0d_idle_stall", v), {31'b0, stall}, 32'h0);
        end

        // Back-to-back LD then ST, each acked in its first BUSY cycle.
        st_pat = '0; req_pat = '0;
        mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h0000_0100; wdata = 32'h0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                mem_rd = 1'b0; mem_wr = 1'b1; addr = 32'h0000_0200; wdata = 32'h600D_CAFE;
            end
            bus_ack = (c == 1 || c == 4); bus_rdata = 32'h0102_0304;
            #1;
            st_pat[5-c] = stall; req_pat[5-c] = bus_req;
            if (c == 4) check("b2b_st_we", {31'b0, bus_we}, 32'h1);
            tick();
            bus_ack = 1'b0;
        end
        mem_wr = 1'b0;
        check("b2b_stall_pat", {26'b0, st_pat}, 32'b110110);
        check("b2b_req_pat", {26'b0, req_pat}, 32'b010010);
        check("b2b_rdata", rdata, 32'h0102_0304);
        tick();

        // Reset during the second BUSY cycle, late ack afterwards.
        mem_rd = 1'b1; addr = 32'h0000_0050;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        tick();
        reset = 1'b0; mem_rd = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        #1;
        check("rst_mid_req", {31'b0, bus_req}, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        tick();
        bus_ack = 1'b0;
        check("rst_late_ack_req", {31'b0, bus_req}, 32'h0);
        check("rst_late_ack_rdata", rdata, 32'h0);
        check("rst_late_ack_stall", {31'b0, stall}, 32'h0);

        // TIMEOUT=4 instance: load that is never acknowledged.
        req_n = 0; done = 1'b0;
        t_mem_rd = 1'b1; t_addr = 32'h0000_0020;
        #1;
        check("to_req_stall", {31'b0, t_stall}, 32'h1);
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (t_bus_req) req_n++;
            tick();
            if (!t_bus_req) begin
                done = 1'b1;
                break;
            end
        end
        check("to_done", {31'b0, done}, 32'h1);
        check("to_busy_cycles", req_n, 4);
        check("to_err", {31'b0, t_bus_err}, 32'h1);
        check("to_rdata", t_rdata, 32'hDEAD_BEEF);
        check("to_stall_release", {31'b0, t_stall}, 32'h0);
        t_mem_rd = 1'b0;
        tick();
        tick();
        check("to_err_sticky", {31'b0, t_bus_err}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
